// File: rtl/b_lut_inv_if.sv
`default_nettype none
// ============================================================================
// Module      : b_lut_inv_if
// Description : Request/response bundle for the nibble-LUT inverter.
//               Request side : in_valid/in_ready handshake carrying crs2/crs3
//                              (LUT entries 0..7 and 8..15).
//               Response side: out_valid/out_ready handshake carrying
//                              result_lo/result_hi (inverse LUT) and perm_ok.
//               master : the requester / result consumer
//               slave  : the inverter block
// Revision    : 1.0 - initial release
// ============================================================================
interface b_lut_inv_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] crs2;
  logic [31:0] crs3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        perm_ok;

  modport master (
    output in_valid, crs2, crs3, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, perm_ok
  );

  modport slave (
    input  in_valid, crs2, crs3, out_ready,
    output in_ready, out_valid, result_lo, result_hi, perm_ok
  );
endinterface
`default_nettype wire

// File: rtl/b_lut_inv.sv
`default_nettype none
// ============================================================================
// Module      : b_lut_inv
// Description : Inverts a 16-entry, 4-bit nibble LUT ({crs3,crs2}, entry i in
//               bits [4i+3:4i]). EPC entries are scanned per cycle, so a
//               result is ready 16/EPC cycles after the request is accepted.
//               A 16-bit seen-mask records which output slots were hit;
//               perm_ok reports whether every slot was hit (bijection).
//               Unhit slots read 0; a slot hit several times keeps the
//               highest source index.
// Ports       : clock  - core clock, rising edge
//               reset  - asynchronous, active-high
//               bus    - b_lut_inv_if.slave (request + result handshakes)
// Parameters  : EPC    - entries per cycle, one of 1,2,4,8,16
// Revision    : 1.0 - initial release
// ============================================================================
module b_lut_inv #(
  parameter int EPC = 4
) (
  input  logic        clock,
  input  logic        reset,
  b_lut_inv_if.slave  bus
);

  localparam int c_num_cycles = 16 / EPC;
  localparam int c_idx_w      = (c_num_cycles > 1) ? $clog2(c_num_cycles) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_idx;
  logic [63:0]          r_lut;
  logic [63:0]          r_inv;
  logic [15:0]          r_seen;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_perm_ok;

  logic [63:0]          w_inv_nxt;
  logic [15:0]          w_seen_nxt;
  logic [3:0]           w_k;
  logic [3:0]           w_ent;
  logic                 w_last;

  assign w_last = (r_idx == c_idx_w'(c_num_cycles - 1));

  // One scan step. Entries are applied in ascending k so that, when two
  // entries of the same step target one slot, the later (higher k) write
  // wins -- identical to a fully sequential walk.
  always_comb begin
    w_inv_nxt  = r_inv;
    w_seen_nxt = r_seen;
    w_k        = '0;
    w_ent      = '0;
    for (int e = 0; e < EPC; e++) begin
      w_k   = 4'(32'(r_idx) * EPC + e);
      w_ent = r_lut[{w_k, 2'b00} +: 4];
      w_inv_nxt[{w_ent, 2'b00} +: 4] = w_k;
      w_seen_nxt[w_ent]              = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_lut       <= '0;
      r_inv       <= '0;
      r_seen      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_perm_ok   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_lut      <= {bus.crs3, bus.crs2};
            r_inv      <= '0;
            r_seen     <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_inv  <= w_inv_nxt;
          r_seen <= w_seen_nxt;
          if (w_last) begin
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_perm_ok   <= &w_seen_nxt;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          // in_ready rises one edge after the handoff, so no request can
          // be taken in the same cycle the result is consumed.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result_lo = r_inv[31:0];
  assign bus.result_hi = r_inv[63:32];
  assign bus.perm_ok   = r_perm_ok;

endmodule
`default_nettype wire

// File: tb/tb_b_lut_inv.sv
`default_nettype none
// ============================================================================
// Module      : tb_b_lut_inv
// Description : Self-checking bench for b_lut_inv. Main instance (EPC=4) is
//               driven from a vector table and random LUTs through a
//               scoreboard queue; five extra instances (EPC=1..16) share one
//               stimulus for random bijections and latency/round-trip checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b_lut_inv;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  b_lut_inv_if bus();
  b_lut_inv #(.EPC(4)) dut (.clock(clock), .reset(reset), .bus(bus));

  // Shared stimulus for the per-EPC instances
  logic        e_in_valid;
  logic        e_out_ready;
  logic [31:0] e_crs2;
  logic [31:0] e_crs3;
  wire  [4:0]  e_in_ready;
  wire  [4:0]  e_out_valid;
  wire  [4:0]  e_ok;
  wire  [31:0] e_lo [5];
  wire  [31:0] e_hi [5];

  for (genvar j = 0; j < 5; j++) begin : g_epc
    b_lut_inv_if ebus();
    assign ebus.in_valid  = e_in_valid;
    assign ebus.out_ready = e_out_ready;
    assign ebus.crs2      = e_crs2;
    assign ebus.crs3      = e_crs3;
    assign e_in_ready[j]  = ebus.in_ready;
    assign e_out_valid[j] = ebus.out_valid;
    assign e_ok[j]        = ebus.perm_ok;
    assign e_lo[j]        = ebus.result_lo;
    assign e_hi[j]        = ebus.result_hi;
    b_lut_inv #(.EPC(1 << j)) u_dut (.clock(clock), .reset(reset), .bus(ebus));
  end

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ok;
  } exp_t;

  typedef struct {
    logic [31:0] c2;
    logic [31:0] c3;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ok;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   acc_cyc = 0;
  logic prev_ov = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic void ref_inv(input logic [63:0] lut, output logic [63:0] inv,
                                  output logic ok);
    logic [15:0] seen;
    int v;
    seen = '0;
    inv  = '0;
    for (int k = 0; k < 16; k++) begin
      v = int'(lut[k*4 +: 4]);
      inv[v*4 +: 4] = 4'(k);
      seen[v] = 1'b1;
    end
    ok = &seen;
  endfunction

  function automatic logic [63:0] rand_perm();
    int p[16];
    int j, t;
    logic [63:0] r;
    for (int i = 0; i < 16; i++) p[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = 4'(p[i]);
    return r;
  endfunction

  // Round trip: inv[lut[x]] must give x for every x
  function automatic int round_trip_bad(input logic [63:0] lut, input logic [63:0] inv);
    int bad;
    int y;
    bad = 0;
    for (int x = 0; x < 16; x++) begin
      y = int'(lut[x*4 +: 4]);
      if (int'(inv[y*4 +: 4]) != x) bad++;
    end
    return bad;
  endfunction

  // Main-instance monitor: accept time, latency, scoreboard pop
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_ov = 1'b0;
      end else begin
        if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
        if (bus.out_valid && !prev_ov) chk_int("latency_epc4", cyc - acc_cyc - 1, 4);
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            timeout("unexpected_output");
          end else begin
            e = sb.pop_front();
            chk32("result_lo", bus.result_lo, e.lo);
            chk32("result_hi", bus.result_hi, e.hi);
            chk32("perm_ok", 32'(bus.perm_ok), 32'(e.ok));
          end
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  task automatic send(input logic [31:0] c2, input logic [31:0] c3, input exp_t e);
    int n;
    @(posedge clock); #1;
    bus.crs2     = c2;
    bus.crs3     = c3;
    bus.in_valid = 1'b1;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) timeout("accept");
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.crs2     = $urandom;   // only the accept cycle matters
    bus.crs3     = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) timeout("drain");
  endtask

  initial begin
    vec_t        tab[3];
    exp_t        e;
    logic [63:0] lut, inv;
    logic        ok;
    logic [4:0]  done;
    int          c, n;

    tab[0] = '{32'h76543210, 32'hFEDCBA98, 32'h76543210, 32'hFEDCBA98, 1'b1};
    tab[1] = '{32'h87654321, 32'h0FEDCBA9, 32'h6543210F, 32'hEDCBA987, 1'b1};
    tab[2] = '{32'h00000000, 32'h00000000, 32'h0000000F, 32'h00000000, 1'b0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.crs2      = '0;
    bus.crs3      = '0;
    e_in_valid    = 1'b0;
    e_out_ready   = 1'b1;
    e_crs2        = '0;
    e_crs3        = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk32("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk32("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk32("rst_lo", bus.result_lo, 32'd0);
    chk32("rst_hi", bus.result_hi, 32'd0);
    chk32("rst_perm_ok", 32'(bus.perm_ok), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Table-driven vectors: identity, rotate, all-zero
    for (int i = 0; i < 3; i++) begin
      e = '{tab[i].lo, tab[i].hi, tab[i].ok};
      send(tab[i].c2, tab[i].c3, e);
      drain();
    end

    // Backpressure: result held for 10 cycles, then handed off
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    e = '{tab[1].lo, tab[1].hi, tab[1].ok};
    send(tab[1].c2, tab[1].c3, e);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.out_valid) timeout("bp_out_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk32("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk32("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk32("bp_lo", bus.result_lo, tab[1].lo);
      chk32("bp_hi", bus.result_hi, tab[1].hi);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    @(negedge clock);            // handoff cycle: scoreboard pops here
    chk32("handoff_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    chk32("post_out_valid", 32'(bus.out_valid), 32'd0);
    chk32("post_in_ready", 32'(bus.in_ready), 32'd1);
    chk32("post_keep_lo", bus.result_lo, tab[1].lo);
    drain();

    // Reset mid-RUN: work discarded, then a fresh request completes
    e = '{tab[2].lo, tab[2].hi, tab[2].ok};
    send(tab[2].c2, tab[2].c3, e);
    sb.delete();
    reset = 1'b1;
    @(negedge clock);
    chk32("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk32("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk32("midrst_lo", bus.result_lo, 32'd0);
    chk32("midrst_hi", bus.result_hi, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    e = '{tab[1].lo, tab[1].hi, tab[1].ok};
    send(tab[1].c2, tab[1].c3, e);
    drain();

    // Random LUTs (bijective and arbitrary) on the main instance
    for (int i = 0; i < 8; i++) begin
      lut = (i < 4) ? rand_perm() : {$urandom, $urandom};
      ref_inv(lut, inv, ok);
      e = '{inv[31:0], inv[63:32], ok};
      send(lut[31:0], lut[63:32], e);
      drain();
    end

    // Random bijections on every legal EPC: result, round trip, latency
    for (int r = 0; r < 6; r++) begin
      lut = rand_perm();
      ref_inv(lut, inv, ok);
      @(posedge clock); #1;
      e_crs2     = lut[31:0];
      e_crs3     = lut[63:32];
      e_in_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (e_in_ready != 5'b11111 && n < 50);
      if (e_in_ready != 5'b11111) timeout("epc_accept");
      c = cyc;
      @(posedge clock); #1;
      e_in_valid = 1'b0;
      e_crs2     = $urandom;
      e_crs3     = $urandom;
      done = '0;
      n = 0;
      while (done != 5'b11111 && n < 40) begin
        @(negedge clock);
        n++;
        for (int j = 0; j < 5; j++) begin
          if (e_out_valid[j] && !done[j]) begin
            done[j] = 1'b1;
            chk_int($sformatf("epc%0d_latency", 1 << j), cyc - c - 1, 16 >> j);
            chk32($sformatf("epc%0d_lo", 1 << j), e_lo[j], inv[31:0]);
            chk32($sformatf("epc%0d_hi", 1 << j), e_hi[j], inv[63:32]);
            chk32($sformatf("epc%0d_perm_ok", 1 << j), 32'(e_ok[j]), 32'd1);
            chk_int($sformatf("epc%0d_round_trip_bad", 1 << j),
                    round_trip_bad(lut, {e_hi[j], e_lo[j]}), 0);
          end
        end
      end
      if (done != 5'b11111) timeout("epc_result");
      repeat (2) @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
